// File: rtl/fetch_pc_controller.sv
// Architectural PC holder and instruction fetch/decode front end for the SEQ Y86-64 core.
// Fetches ten bytes at pc, splits them into fields, and waits for pc_done before the next fetch.
module fetch_pc_controller #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          IMEM_BYTES  = 4096,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [79:0] imem_rdata,
    input  logic        imem_error,
    input  logic [63:0] new_pc,
    input  logic        pc_done,
    output logic        instr_valid,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat
);
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_STOP} state_t;

    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_HLT = 3'd2;
    localparam logic [2:0]  STAT_ADR = 3'd3;
    localparam logic [2:0]  STAT_INS = 3'd4;
    localparam int          CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [63:0] PC_LIMIT = 64'(IMEM_BYTES);

    state_t        state;
    logic [CW-1:0] tmo_cnt;

    logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
    logic        need_regids, need_valc, instr_ok;
    logic [63:0] d_valc, d_valp;

    assign imem_addr = pc;

    always_comb begin
        d_icode     = imem_rdata[7:4];
        d_ifun      = imem_rdata[3:0];
        need_regids = 1'b0;
        need_valc   = 1'b0;
        instr_ok    = 1'b0;
        case (d_icode)
            4'h2, 4'h7: instr_ok = (d_ifun <= 4'd6);
            4'h6:       instr_ok = (d_ifun <= 4'd3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        instr_ok = (d_ifun == 4'd0);
            default:    instr_ok = 1'b0;
        endcase
        case (d_icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            default: need_regids = 1'b0;
        endcase
        case (d_icode)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
            default: need_valc = 1'b0;
        endcase
        d_ra = need_regids ? imem_rdata[15:12] : 4'hF;
        d_rb = need_regids ? imem_rdata[11:8]  : 4'hF;
        // The constant starts one byte later when a register byte is present.
        if (!need_valc)       d_valc = 64'd0;
        else if (need_regids) d_valc = imem_rdata[79:16];
        else                  d_valc = imem_rdata[71:8];
        d_valp = pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            stat        <= STAT_AOK;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            icode       <= 4'h1;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= 64'd0;
            valP        <= 64'd0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (pc >= PC_LIMIT) begin
                        imem_req <= 1'b0;
                        stat     <= STAT_ADR;
                        state    <= S_STOP;
                    end else if (imem_req && imem_ack) begin
                        // An ack only counts against a request already on the bus.
                        imem_req <= 1'b0;
                        if (imem_error) begin
                            stat  <= STAT_ADR;
                            state <= S_STOP;
                        end else begin
                            icode <= d_icode;
                            ifun  <= d_ifun;
                            rA    <= d_ra;
                            rB    <= d_rb;
                            valC  <= d_valc;
                            valP  <= d_valp;
                            if (!instr_ok) begin
                                stat  <= STAT_INS;
                                state <= S_STOP;
                            end else if (d_icode == 4'h0) begin
                                stat  <= STAT_HLT;
                                state <= S_STOP;
                            end else begin
                                instr_valid <= 1'b1;
                                state       <= S_ISSUE;
                            end
                        end
                    end else if (tmo_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        imem_req <= 1'b0;
                        stat     <= STAT_ADR;
                        state    <= S_STOP;
                    end else begin
                        imem_req <= 1'b1;
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (pc_done) begin
                        pc          <= new_pc;
                        instr_valid <= 1'b0;
                        tmo_cnt     <= '0;
                        imem_req    <= (new_pc < PC_LIMIT);
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
